// File: rtl/rr_arbiter_4.sv
// Four-way arbiter with fixed-priority and round-robin selection,
// per-grant release strobes and a hold-limit forced release.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  input  logic       mode,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] id_nx;
  logic [1:0] last_id, last_nx;
  logic [7:0] hold, hold_nx;
  logic       to_nx;

  logic [1:0] fix_id;
  logic [1:0] rr_id;
  logic [1:0] rr_start;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic [1:0] win;
  logic       rel_early;
  logic       rel_hold;

  // Highest set bit wins: later iterations override earlier ones.
  always_comb begin
    fix_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) fix_id = i[1:0];
    end
  end

  always_comb begin
    rr_start = last_id + 2'd1;
    rr_id    = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = rr_start + i[1:0];
      if (!rr_found && req[rr_idx]) begin
        rr_id    = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign win       = mode ? rr_id : fix_id;
  assign rel_early = done[grant_id] | ~req[grant_id];
  assign rel_hold  = (hold == HOLD_LAST);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    id_nx    = grant_id;
    last_nx  = last_id;
    hold_nx  = hold;
    to_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        grant_nx = 4'b0000;
        if (|req) begin
          state_nx = GRANT;
          grant_nx = 4'b0001 << win;
          id_nx    = win;
          last_nx  = win;
          hold_nx  = 8'd0;
        end
      end
      GRANT: begin
        if (rel_early || rel_hold) begin
          state_nx = IDLE;
          grant_nx = 4'b0000;
          hold_nx  = 8'd0;
          to_nx    = rel_hold & ~rel_early;
        end else begin
          hold_nx = hold + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      grant_id <= 2'd0;
      last_id  <= 2'd3;
      hold     <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      grant_id <= id_nx;
      last_id  <= last_nx;
      hold     <= hold_nx;
      timeout  <= to_nx;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles a grant is held before a forced release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: the request from each of 4 requesters, held high until served.
REQ-005 The block SHALL have port done, input, 4 bits: per-requester release strobe, one cycle.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-007 The block SHALL have port grant, output, 4 bits: one-hot grant, registered.
REQ-008 The block SHALL have port grant_id, output, 2 bits: binary index of the granted requester, registered.
REQ-009 The block SHALL have port grant_valid, output, 1 bit: high while any grant is active.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-011 The block SHALL implement two states, IDLE and GRANT.
REQ-012 In IDLE with req != 0, the block SHALL select a winner and, on the next edge, enter GRANT with grant = one-hot(winner), grant_id = winner, grant_valid = 1, and the hold counter cleared. Latency from req sampled to grant visible is 1 cycle.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with grant = 0, grant_valid = 0, and grant_id holding its last value.
REQ-014 Fixed mode (mode = 0): req[3] is highest priority and req[0] lowest, i.e. the index of the highest set bit wins.
REQ-015 Round-robin mode (mode = 1): the search SHALL start at (last_id + 1) mod 4, ascending with wrap-around, and the first set bit wins. last_id is the most recently granted index.
REQ-016 last_id SHALL update to the winner on every grant, in both modes.
REQ-017 mode SHALL be sampled only at arbitration in IDLE; a change during GRANT takes effect at the next arbitration.
REQ-018 In GRANT, the hold counter SHALL increment by 1 each cycle, 8 bits wide, with no wrap beyond MAX_HOLD-1.
REQ-019 In GRANT, a release event SHALL occur when any of the following holds: done[grant_id] = 1; req[grant_id] = 0; or the hold counter = MAX_HOLD-1.
REQ-020 On a release event, the block SHALL return to IDLE on the next edge with grant = 0 and grant_valid = 0. This guarantees at least 1 idle cycle between consecutive grants.
REQ-021 A timeout SHALL pulse high for exactly 1 cycle, coincident with the first IDLE cycle, only when the release was caused solely by the hold limit.
REQ-022 If done[grant_id] or a dropped req coincides with the hold limit, the block SHALL treat it as a normal release with timeout = 0.
REQ-023 done bits for non-granted requesters SHALL be ignored in all states, and done in IDLE SHALL be ignored.
REQ-024 grant SHALL always be one-hot or zero, and grant_valid SHALL equal |grant.
REQ-025 A grant SHALL be held for at most MAX_HOLD cycles.

Reset
REQ-026 While rst = 1 at an edge, the block SHALL set state = IDLE, grant = 4'b0000, grant_id = 2'b00, grant_valid = 0, timeout = 0, hold counter = 0, and last_id = 3 (so the first round-robin search starts at index 0).
REQ-027 Reset asserted during GRANT SHALL abort the grant in the same edge, with no timeout pulse and no last_id update.
REQ-028 After rst deasserts, the block SHALL begin arbitration on the first edge with req != 0.

Verification
REQ-029 Fixed priority: mode = 0, req = 4'b0110 -> next cycle grant = 4'b0100, grant_id = 2; done = 4'b0100 -> next cycle grant = 0; the following arbitration cycle -> grant = 4'b0010.
REQ-030 Round-robin rotation: mode = 1, req = 4'b1111 held, each grant released by done after 1 cycle -> grant_id sequence 0,1,2,3,0, with one idle cycle between each grant.
REQ-031 Timeout: MAX_HOLD = 4, req = 4'b0001 held, done never asserted -> grant high for exactly 4 cycles, then grant = 0 with timeout = 1 for 1 cycle, then the block re-grants requester 0.
REQ-032 Simultaneous release: MAX_HOLD = 4, done[grant_id] asserted in the 4th grant cycle -> release occurs with timeout = 0.
REQ-033 Reset mid-grant: rst = 1 while grant = 4'b1000 -> next cycle all outputs are 0; with mode = 1, req = 4'b1001 after reset -> grant_id = 0.
REQ-034 Request withdrawal and stray done: req[grant_id] drops during GRANT -> release on the next edge; done for a non-granted bit -> no effect on grant.
